// File: rtl/cmd_issue.sv
// Host command front-end for the 8-bit deque core: buffers host commands, admits them
// against a shadow occupancy count, issues one per slot and returns READ results.
// Optional rejected-command counter enabled by CMD_ISSUE_DROP_CNT_EN.
module cmd_issue #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CORE_DEPTH  = 8,
    parameter int unsigned RSP_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] in,
    output logic [2:0] op,
    output logic       apply,
    input  logic [7:0] tail,
    input  logic       empty,
    input  logic       valid,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       err,
    output logic [7:0] drop_cnt
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(CORE_DEPTH + 1);
    localparam int unsigned TW = $clog2(RSP_TIMEOUT + 1);

    localparam logic [2:0] OP_PUSH = 3'b101;
    localparam logic [2:0] OP_POP  = 3'b011;
    localparam logic [2:0] OP_READ = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state, state_d;
    logic [2:0]      op_mem   [FIFO_DEPTH];
    logic [7:0]      data_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_d;
    logic [OW-1:0]   occ, occ_d;
    logic [TW-1:0]   tmo_cnt, tmo_d;
    logic [2:0]      head_op, op_d;
    logic [7:0]      head_data, in_d, rsp_data_d;
    logic            wr_en, rd_en, reject_c, apply_d, rsp_valid_d, err_d;

    assign wr_en     = cmd_valid && cmd_ready;
    assign head_op   = op_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign count_d   = count + CW'(wr_en) - CW'(rd_en);

    // Admission decision on the FIFO head, judged only by the shadow occupancy.
    assign reject_c = (state == S_IDLE) && (count != '0) &&
                      ((((head_op == OP_POP) || (head_op == OP_READ)) && (occ == '0)) ||
                       ((head_op == OP_PUSH) && (occ == OW'(CORE_DEPTH))));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            op_mem[wr_ptr]   <= cmd_op;
            data_mem[wr_ptr] <= cmd_data;
        end
    end

    always_comb begin
        state_d     = state;
        occ_d       = occ;
        tmo_d       = tmo_cnt;
        rd_en       = 1'b0;
        apply_d     = 1'b0;
        op_d        = op;
        in_d        = in;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        err_d       = reject_c || ((state == S_IDLE) && empty && (occ != '0));
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    rd_en = 1'b1;
                    if (!reject_c) begin
                        state_d = S_ISSUE;
                        apply_d = 1'b1;
                        op_d    = head_op;
                        in_d    = (head_op == OP_PUSH) ? head_data : 8'h00;
                        if (head_op == OP_PUSH) occ_d = occ + OW'(1);
                        if (head_op == OP_POP)  occ_d = occ - OW'(1);
                    end
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = (op == OP_READ) ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = tail;
                    state_d     = S_IDLE;
                end else if (tmo_cnt == TW'(RSP_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_cnt + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            occ       <= '0;
            tmo_cnt   <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_ready <= 1'b0;
            apply     <= 1'b0;
            op        <= 3'b000;
            in        <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            occ       <= occ_d;
            tmo_cnt   <= tmo_d;
            count     <= count_d;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            cmd_ready <= (count_d != CW'(FIFO_DEPTH));
            apply     <= apply_d;
            op        <= op_d;
            in        <= in_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            err       <= err_d;
        end
    end

`ifdef CMD_ISSUE_DROP_CNT_EN
    logic [7:0] drop_q;

    // Saturating count of admission rejects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 8'h00;
        end else if (reject_c && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_cmd_issue.sv
// Scoreboard bench for cmd_issue: stimulus pushes expectations, a negedge monitor checks
// apply/rsp/err events; a small core responder answers READs as scripted.
`timescale 1ns/1ps
module tb_cmd_issue;
    localparam logic [2:0] PUSH = 3'b101;
    localparam logic [2:0] POP  = 3'b011;
    localparam logic [2:0] READ = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] in;
    logic [2:0] op;
    logic       apply;
    logic [7:0] tail;
    logic       empty, valid;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       err;
    logic [7:0] drop_cnt;

    logic       force_empty;
    int         core_occ;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_read_cyc = 0;
    int         m_occ = 0;
    int         m_drop = 0;
    int         w;

    logic [10:0] exp_apply[$];
    logic [7:0]  exp_rsp[$];
    int          exp_err[$];
    logic [8:0]  rsp_plan[$];

    cmd_issue dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .in(in), .op(op), .apply(apply),
        .tail(tail), .empty(empty), .valid(valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Simple core occupancy so the consistency input tracks real applies.
    always @(posedge clk or negedge rst) begin
        if (!rst) core_occ <= 0;
        else if (apply && op == PUSH) core_occ <= core_occ + 1;
        else if (apply && op == POP) core_occ <= core_occ - 1;
    end
    assign empty = (core_occ == 0) || force_empty;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_drop(input string nm);
`ifdef CMD_ISSUE_DROP_CNT_EN
        chk(nm, 32'(drop_cnt), 32'(m_drop));
`else
        chk(nm, 32'(drop_cnt), 32'd0);
`endif
    endtask

    // Reference admission model; tag 0 = reject, 1 = response timeout, 2 = empty mismatch.
    task automatic model(input logic [2:0] o, input logic [7:0] d, input bit rsp_en,
                         input logic [7:0] rsp_t);
        if (((o == POP || o == READ) && m_occ == 0) || (o == PUSH && m_occ == 8)) begin
            exp_err.push_back(0);
            if (m_drop != 255) m_drop++;
        end else begin
            exp_apply.push_back({o, (o == PUSH) ? d : 8'h00});
            if (o == PUSH) m_occ++;
            if (o == POP) m_occ--;
            if (o == READ) begin
                rsp_plan.push_back({rsp_en, rsp_t});
                if (rsp_en) exp_rsp.push_back(rsp_t);
                else exp_err.push_back(1);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [2:0] o, input logic [7:0] d, input bit rsp_en,
                        input logic [7:0] rsp_t, output int waited);
        waited = 0;
        cmd_valid = 1'b1;
        cmd_op = o;
        cmd_data = d;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("handshake", 32'(cmd_ready), 32'd1);
        if (cmd_ready) model(o, d, rsp_en, rsp_t);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every output event must match the head of its expectation queue.
    initial begin
        int t;
        logic [10:0] ea;
        forever begin
            @(negedge clk);
            cyc++;
            if (apply) begin
                chk("apply_expected", 32'(exp_apply.size() > 0), 32'd1);
                if (exp_apply.size() > 0) begin
                    ea = exp_apply.pop_front();
                    chk("apply_op_in", {21'd0, op, in}, {21'd0, ea});
                end
                if (op == READ) last_read_cyc = cyc;
            end
            if (rsp_valid) begin
                chk("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
                if (exp_rsp.size() > 0) chk("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
            end
            if (err) begin
                chk("err_expected", 32'(exp_err.size() > 0), 32'd1);
                if (exp_err.size() > 0) begin
                    t = exp_err.pop_front();
                    if (t == 1) chk("timeout_delay", 32'(cyc - last_read_cyc), 32'd5);
                end
            end
        end
    end

    // Core responder: answers a READ in the first cycle after its apply when scripted to.
    initial begin
        logic [8:0] p;
        valid = 1'b0;
        tail = 8'hEE;
        forever begin
            @(negedge clk);
            if (rst && apply && op == READ) begin
                p = (rsp_plan.size() > 0) ? rsp_plan.pop_front() : 9'h000;
                if (p[8]) begin
                    @(posedge clk);
                    #1 valid = 1'b1;
                    tail = p[7:0];
                    @(posedge clk);
                    #1 valid = 1'b0;
                    tail = 8'hEE;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 3'b000;
        cmd_data = 8'h00;
        force_empty = 1'b0;
        idle(2);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_apply", 32'(apply), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_in", 32'(in), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // READ with nothing in the core is rejected
        send(READ, 8'h00, 1'b1, 8'h00, w);
        idle(4);
        chk_drop("drop_after_read_reject");

        // Three back-to-back pushes; ready must stay high
        send(PUSH, 8'h02, 1'b0, 8'h00, w); chk("ready_b2b", 32'(w), 32'd0);
        send(PUSH, 8'h04, 1'b0, 8'h00, w); chk("ready_b2b", 32'(w), 32'd0);
        send(PUSH, 8'h01, 1'b0, 8'h00, w); chk("ready_b2b", 32'(w), 32'd0);
        idle(8);

        // POP then READ answered with 8'h04
        send(POP, 8'h00, 1'b0, 8'h00, w);
        send(READ, 8'h00, 1'b1, 8'h04, w);
        idle(10);

        // Empty flag contradicting occ=2 while idle
        exp_err.push_back(2);
        force_empty = 1'b1;
        @(negedge clk);
        force_empty = 1'b0;
        idle(3);

        // Stray core valid outside WAIT produces nothing
        valid = 1'b1;
        tail = 8'h77;
        @(negedge clk);
        valid = 1'b0;
        tail = 8'hEE;
        idle(3);

        // Fill the core to 8, then one PUSH too many
        for (int i = 0; i < 6; i++) send(PUSH, 8'(8'h10 + i), 1'b0, 8'h00, w);
        send(PUSH, 8'h99, 1'b0, 8'h00, w);
        idle(6);
        chk_drop("drop_after_overflow");

        // Unanswered READ; five commands behind it fill the FIFO
        send(READ, 8'h00, 1'b0, 8'h00, w);
        send(POP, 8'h00, 1'b0, 8'h00, w);
        send(POP, 8'h00, 1'b0, 8'h00, w);
        send(PUSH, 8'h33, 1'b0, 8'h00, w);
        send(READ, 8'h00, 1'b1, 8'h5A, w);
        send(POP, 8'h00, 1'b0, 8'h00, w);
        chk("fifo_full_stall", 32'(w > 0), 32'd1);
        idle(20);
        chk_drop("drop_after_timeout");

        // Async reset while waiting on a READ with two commands queued
        send(READ, 8'h00, 1'b0, 8'h00, w);
        send(PUSH, 8'h01, 1'b0, 8'h00, w);
        send(PUSH, 8'h02, 1'b0, 8'h00, w);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_apply", 32'(apply), 32'd0);
        chk("mid_rst_op", 32'(op), 32'd0);
        chk("mid_rst_in", 32'(in), 32'd0);
        chk("mid_rst_rsp", {23'd0, rsp_valid, rsp_data}, 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        exp_apply.delete();
        exp_rsp.delete();
        exp_err.delete();
        rsp_plan.delete();
        m_occ = 0;
        m_drop = 0;
        idle(2);
        rst = 1'b1;
        idle(12);

        // Shadow occupancy was cleared: READ is rejected again
        send(READ, 8'h00, 1'b1, 8'h00, w);
        idle(6);
        chk_drop("drop_after_reset");

        chk("left_apply", 32'(exp_apply.size()), 32'd0);
        chk("left_rsp", 32'(exp_rsp.size()), 32'd0);
        chk("left_err", 32'(exp_err.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmd_issue.md
Name: cmd_issue

Overview:
- Upstream command front-end for the 8-bit deque core (core ports in, op, apply, tail, empty, valid).
- Accepts host commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one command to the core per cycle and rejects commands that would underflow or overflow the core.
- Returns tail results of READ commands to the host.

Parameters:
- FIFO_DEPTH, 4, host command buffer entries (power of 2, ≥2).
- CORE_DEPTH, 8, capacity of the downstream core; used by the shadow occupancy counter.
- RSP_TIMEOUT, 4, cycles to wait for core valid after READ before flagging error.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  FIFO can accept; transfer when cmd_valid&&cmd_ready.
- cmd_op  input  3  command opcode.
- cmd_data  input  8  push payload.
- in  output  8  data to core.
- op  output  3  opcode to core.
- apply  output  1  one-cycle strobe to core.
- tail  input  8  core tail value.
- empty  input  1  core empty flag.
- valid  input  1  core result valid.
- rsp_valid  output  1  one-cycle pulse, rsp_data valid.
- rsp_data  output  8  READ result.
- err  output  1  one-cycle pulse: rejected command or response timeout.
- drop_cnt  output  8  rejected-command count (see Optional Feature).

Behaviour:
- Opcodes: 3'b101 PUSH (+1 occupancy), 3'b011 POP (−1), 3'b100 READ (no change, expects a result). Any other opcode is forwarded as-is with no occupancy change and no response wait.
- Reset (rst=0, any time, async): FIFO emptied, occ=0, state IDLE; cmd_ready=0 while in reset and 1 in the first cycle after release. in=0, op=0, apply=0, rsp_valid=0, rsp_data=0, err=0, drop_cnt=0. A command or response in flight is discarded.
- FIFO: write on handshake; cmd_ready = !full. Simultaneous write and read when full is not allowed: ready already low. Simultaneous write and read when empty is allowed; the entry is still stored and popped, so there is no bypass.
- Shadow occupancy occ (0..CORE_DEPTH) is the authority for admission. The core empty input is used only for a consistency check; a mismatch (empty=1 while occ≠0, sampled in IDLE) raises err.
- FSM:
  - IDLE: if FIFO non-empty, pop the head and evaluate it.
    - POP or READ with occ==0 → reject.
    - PUSH with occ==CORE_DEPTH → reject.
    - Reject = err pulse, drop_cnt+1, stay IDLE.
    - Otherwise go to ISSUE.
  - ISSUE (1 cycle): apply=1, op/in driven from the entry (in=0 for non-PUSH), occ updated. Next state is WAIT for READ, else IDLE.
  - WAIT: on valid=1 → rsp_data=tail, rsp_valid=1, go to IDLE. After RSP_TIMEOUT cycles without valid → err pulse, go to IDLE.
- Throughput: one command per 2 cycles (IDLE+ISSUE), plus at least 1 extra cycle for READ. Latency from handshake to apply is ≥2 cycles.
- in and op hold their last values when apply=0.
- A core valid outside WAIT is ignored.
- occ and drop_cnt are clamped: drop_cnt saturates at 255.

Optional Feature:
- CMD_ISSUE_DROP_CNT_EN.
- Defined: drop_cnt counts rejected commands as above.
- Undefined: drop_cnt is tied to 8'h00 and the counter logic is removed; err behaviour is unchanged.

Test Plan:
- Reset release, then PUSH 8'h02, 8'h04, 8'h01 back-to-back → three apply pulses with op=101 and in=02,04,01 in order; occ=3; cmd_ready never drops.
- POP then READ, with the core returning valid and tail=8'h04 one cycle after apply → op=011 then op=100 issued; rsp_valid pulse with rsp_data=8'h04; occ=2.
- After reset, READ with occ=0 → no apply, err pulse, drop_cnt=1 (macro on) or 0 (macro off).
- Issue 8 PUSHes (CORE_DEPTH=8), then a 9th PUSH → 9th is rejected with err and no apply; 5 host commands sent with no drains → cmd_ready=0 after the FIFO fills, and 4 are buffered.
- READ issued with the core never asserting valid → err pulse exactly RSP_TIMEOUT=4 cycles after WAIT entry; FSM returns to IDLE and the next command issues.
- Assert rst=0 asynchronously mid-WAIT with 2 FIFO entries queued → all outputs go to reset values immediately; no apply after release until new commands arrive.
